// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock ratio meter.
//   - meter_state_t : FSM state encoding (IDLE / MEASURE / LOCKED)
//   - CNT_W_DEF      : default width of the period and phase counters
//   - LOCK_COUNT_DEF : default number of consecutive equal periods for lock
package clk_meas_pkg;

  localparam int CNT_W_DEF      = 8;
  localparam int LOCK_COUNT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } meter_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing an asynchronous level into the clk domain.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, flops reset to 0
//   d     : asynchronous input
//   q     : synchronized output (two clk cycles of latency)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures the period (in clk_in cycles) and high time of a divided clock
// sig_in, flags odd ratios and duty imbalance, and declares lock once the
// period has been stable for LOCK_COUNT consecutive measurements.
// Ports:
//   clk_in   : sampling clock
//   rst_n    : asynchronous active-low reset
//   sig_in   : clock under test, asynchronous to clk_in
//   period   : last measured period, rising edge to rising edge
//   high_cnt : synchronized high samples within the last period
//   valid    : one-cycle pulse, outputs above refreshed in this cycle
//   odd      : period[0]
//   duty_err : |high_cnt - (period - high_cnt)| > 1
//   locked   : period stable for LOCK_COUNT measurements
//   overflow : one-cycle pulse when the period counter saturates
//   state    : current FSM state (debug)
//
// valid is a pure strobe with no back-pressure: when valid is 1 for one
// clk_in cycle, period/high_cnt/odd/duty_err hold the new measurement; the
// consumer must capture it then, there is no ready.
module clk_ratio_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             valid,
  output logic             odd,
  output logic             duty_err,
  output logic             locked,
  output logic             overflow,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [3:0]       MATCH_MAX = 4'(LOCK_COUNT - 1);

  meter_state_t     st;
  logic             sig_sync;
  logic             sig_dly;
  logic             rise;
  // Two extra stages on both the rise strobe and the sampled level so that
  // valid lands exactly four cycles after the first sample of a new high
  // level, while keeping period and high counts aligned.
  logic             rise_p1, rise_p2;
  logic             hi_p1, hi_p2;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [3:0]       match_cnt;
  logic [3:0]       match_nxt;
  logic [CNT_W:0]   two_h;
  logic [CNT_W:0]   per_ext;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk_in),
    .rst_n (rst_n),
    .d     (sig_in),
    .q     (sig_sync)
  );

  assign rise = sig_sync & ~sig_dly;

  // Compare the count that is about to be published with the one on display.
  always_comb begin
    match_nxt = '0;
    if (per_cnt == period) begin
      match_nxt = (match_cnt == MATCH_MAX) ? match_cnt : match_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      sig_dly   <= 1'b0;
      rise_p1   <= 1'b0;
      rise_p2   <= 1'b0;
      hi_p1     <= 1'b0;
      hi_p2     <= 1'b0;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      match_cnt <= '0;
      period    <= '0;
      high_cnt  <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      sig_dly  <= sig_sync;
      rise_p1  <= rise;
      rise_p2  <= rise_p1;
      hi_p1    <= sig_sync;
      hi_p2    <= hi_p1;
      valid    <= 1'b0;
      overflow <= 1'b0;
      // locked follows the state one cycle late
      locked   <= (st == ST_LOCKED);
      case (st)
        ST_IDLE: begin
          per_cnt   <= '0;
          hi_cnt    <= '0;
          match_cnt <= '0;
          if (rise_p2) begin
            st      <= ST_MEASURE;
            per_cnt <= CNT_W'(1);
            hi_cnt  <= CNT_W'(hi_p2);
          end
        end
        default: begin
          // Saturation wins over a coincident rise: that rise is dropped.
          if (per_cnt == CNT_MAX) begin
            overflow  <= 1'b1;
            locked    <= 1'b0;
            st        <= ST_IDLE;
            per_cnt   <= '0;
            hi_cnt    <= '0;
            match_cnt <= '0;
          end else if (rise_p2) begin
            period    <= per_cnt;
            high_cnt  <= hi_cnt;
            valid     <= 1'b1;
            per_cnt   <= CNT_W'(1);
            hi_cnt    <= CNT_W'(hi_p2);
            match_cnt <= match_nxt;
            // A saturated match keeps LOCKED; any mismatch clears to 0.
            st        <= (match_nxt == MATCH_MAX) ? ST_LOCKED : ST_MEASURE;
          end else begin
            per_cnt <= per_cnt + CNT_W'(1);
            hi_cnt  <= hi_cnt + CNT_W'(hi_p2);
          end
        end
      endcase
    end
  end

  // |h - (p - h)| > 1  <=>  2h > p + 1  or  p > 2h + 1
  assign two_h    = {high_cnt, 1'b0};
  assign per_ext  = {1'b0, period};
  assign duty_err = (two_h > per_ext + (CNT_W+1)'(1)) ||
                    (per_ext > two_h + (CNT_W+1)'(1));
  assign odd      = period[0];
  assign state    = st;

endmodule

// File: tb/tb_clk_ratio_meter.sv
module tb_clk_ratio_meter;
  import clk_meas_pkg::*;

  localparam int CNT_W      = 8;
  localparam int LOCK_COUNT = 4;
  localparam int W2         = 2 * CNT_W;

  // ---------------- clock / reset ----------------
  logic             clk_in = 1'b0;
  logic             rst_n  = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_cnt;
  logic             valid;
  logic             odd;
  logic             duty_err;
  logic             locked;
  logic             overflow;
  logic [1:0]       state;

  always #5 clk_in = ~clk_in;

  clk_ratio_meter #(.CNT_W(CNT_W), .LOCK_COUNT(LOCK_COUNT)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .period   (period),
    .high_cnt (high_cnt),
    .valid    (valid),
    .odd      (odd),
    .duty_err (duty_err),
    .locked   (locked),
    .overflow (overflow),
    .state    (state)
  );

  // ---------------- scoreboard state ----------------
  int           total = 0;
  int           bad   = 0;
  logic [W2-1:0] exp_q[$];

  // sig_in generator controls: rises always land 2 time units after a
  // rising clk_in edge, half-periods are multiples of 5.
  bit  gen_en    = 1'b0;
  bit  have_prev = 1'b0;
  int  gen_hi    = 35;
  int  gen_lo    = 35;
  int  prev_hi   = 0;
  int  prev_lo   = 0;
  time last_rise = 0;

  // lock model and overflow tracking
  int  m_match  = 0;
  int  m_prev   = 0;
  bit  m_lk     = 1'b0;
  int  ovf_cnt  = 0;
  time ovf_time = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Period is whole clk_in cycles; high samples are the clk_in rising edges
  // falling strictly inside the high phase that starts 2 units after an edge.
  function automatic logic [W2-1:0] mk_exp(input int hi, input int lo);
    int p;
    int h;
    p = (hi + lo) / 10;
    h = (hi + 1) / 10;
    return {CNT_W'(p), CNT_W'(h)};
  endfunction

  // ---------------- driver: sig_in generator ----------------
  initial begin
    forever begin
      if (gen_en) begin
        sig_in = 1'b1;
        if (have_prev) exp_q.push_back(mk_exp(prev_hi, prev_lo));
        prev_hi   = gen_hi;
        prev_lo   = gen_lo;
        have_prev = 1'b1;
        last_rise = $time;
        #(prev_hi);
        sig_in = 1'b0;
        #(prev_lo);
      end else begin
        @(posedge clk_in);
        #2;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_in) begin
    logic [W2-1:0] e;
    int ep;
    int eh;
    bit ed;
    if (!rst_n) begin
      m_match = 0;
      m_prev  = 0;
      m_lk    = 1'b0;
    end else begin
      if (overflow) begin
        ovf_cnt++;
        ovf_time = $time;
        m_match  = 0;
        m_lk     = 1'b0;
      end
      chk("locked", locked, m_lk);
      if (valid) begin
        chk("exp_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e  = exp_q.pop_front();
          ep = int'(e[W2-1:CNT_W]);
          eh = int'(e[CNT_W-1:0]);
          ed = ((2 * eh - ep) > 1) || ((ep - 2 * eh) > 1);
          chk("period", period, ep);
          chk("high_cnt", high_cnt, eh);
          chk("odd", odd, ep % 2);
          chk("duty_err", duty_err, ed);
          chk("latency", 32'($time - last_rise), 53);
          if (ep == m_prev) m_match = (m_match < LOCK_COUNT - 1) ? m_match + 1 : m_match;
          else m_match = 0;
          m_prev = ep;
          m_lk   = (m_match == LOCK_COUNT - 1);
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_high_cnt"}, high_cnt, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_odd"}, odd, 0);
    chk({tag, "_duty_err"}, duty_err, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_state"}, state, ST_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1;
    chk_all_zero("reset");
    #20;
    rst_n = 1'b1;

    // divide-by-7, 50% duty
    gen_hi = 35; gen_lo = 35; gen_en = 1'b1;
    #(70 * 9);
    chk("div7_locked", locked, 1);
    chk("div7_period", period, 7);

    // switch to divide-by-9
    gen_hi = 45; gen_lo = 45;
    #(90 * 7);
    chk("div9_locked", locked, 1);
    chk("div9_period", period, 9);

    // divide-by-8
    gen_hi = 40; gen_lo = 40;
    #(80 * 8);
    chk("div8_period", period, 8);
    chk("div8_high", high_cnt, 4);
    chk("div8_locked", locked, 1);

    // 1-high / 6-low pulse train
    gen_hi = 10; gen_lo = 60;
    #(70 * 4);
    chk("pulse_high", high_cnt, 1);
    chk("pulse_duty_err", duty_err, 1);

    // back to divide-by-7 and lock
    gen_hi = 35; gen_lo = 35;
    #(70 * 8);
    chk("relock7_locked", locked, 1);

    // reset pulse inside the low phase while locked
    @(negedge sig_in);
    #20;
    rst_n = 1'b0;
    exp_q.delete();
    have_prev = 1'b0;
    #1;
    chk_all_zero("midreset");
    #9;
    rst_n = 1'b1;
    #(70 * 6);
    chk("postreset_locked", locked, 1);

    // divide-by-8 then hold sig_in low until the counter saturates
    gen_hi = 40; gen_lo = 40;
    #(80 * 4);
    gen_en = 1'b0;
    #3000;
    chk("ovf_count", ovf_cnt, 1);
    chk("ovf_time", 32'(ovf_time - last_rise), 2603);
    chk("ovf_state", state, ST_IDLE);
    chk("ovf_locked", locked, 0);
    chk("ovf_period", period, 8);
    chk("ovf_high", high_cnt, 4);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
